// File: rtl/uart_rx_deserializer.sv
// ---------------------------------------------------------------------------
// uart_rx_deserializer
//
// UART receiver for 8N1 frames, LSB first; the counterpart of the saidaUART
// transmitter. The line is oversampled with the system clock. The start bit
// is qualified at mid-bit. Each data bit is then sampled one full bit period
// after the previous sample. The byte is delivered with a ready/acknowledge
// handshake. Framing errors and overruns are reported.
//
// Optional feature (compile-time macro UART_RX_PARITY_EN):
//   When defined, a parity bit follows the data bits. PARITY_ODD selects
//   odd (1) or even (0) parity. When undefined, ParErr is constant 0.
//
// Parameters:
//   OVERSAMPLE  clock cycles per bit period (even, >= 4)
//   PARITY_ODD  0 = even parity, 1 = odd parity (parity build only)
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous, active-high reset
//   SerialIn    serial line, idle high, asynchronous to clock
//   Ack         consumer acknowledge; clears DataReady, Overrun, ParErr
//   ParalelOut  last good byte, held until the next good byte
//   DataReady   level, high while an unacknowledged byte is present
//   FrameErr    one-cycle pulse when the stop bit is sampled low
//   Overrun     sticky; a byte arrived while DataReady was still high
//   ParErr      parity mismatch on the current byte
//   Idle        high while the receiver is in IDLE
// ---------------------------------------------------------------------------
module uart_rx_deserializer #(
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       SerialIn,
    input  logic       Ack,
    output logic [7:0] ParalelOut,
    output logic       DataReady,
    output logic       FrameErr,
    output logic       Overrun,
    output logic       ParErr,
    output logic       Idle
);

    localparam int CNT_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    // The counter value seen just before the sampling edge.
    // cnt_r restarts at 0 on the edge that enters a state.
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             sync1_r;
    logic             sync2_r;
    logic             rx_s;

`ifdef UART_RX_PARITY_EN
    localparam logic ODD_SENSE = (PARITY_ODD != 0);

    logic par_mis_r;

    // High when the received parity bit disagrees with the data bits.
    function automatic logic parity_mismatch(input logic [7:0] data,
                                             input logic       par_bit);
        return (^data) ^ par_bit ^ ODD_SENSE;
    endfunction
`else
    assign ParErr = 1'b0;
`endif

    // Two-flop synchronizer. It presets to the idle (high) line level so
    // that reset itself never looks like a start bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= SerialIn;
            sync2_r <= sync1_r;
        end
    end

    assign rx_s = sync2_r;
    assign Idle = (state_r == IDLE);

    // Receive FSM: frame timing, bit shifting, byte delivery and handshake flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
            ParalelOut <= 8'h00;
            DataReady  <= 1'b0;
            FrameErr   <= 1'b0;
            Overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            ParErr     <= 1'b0;
            par_mis_r  <= 1'b0;
`endif
        end else begin
            FrameErr <= 1'b0;

            // Acknowledge clears the flags. A delivery later in this block
            // overrides these assignments, so a byte that completes on the
            // same edge as Ack is kept.
            if (Ack) begin
                DataReady <= 1'b0;
                Overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
                ParErr    <= 1'b0;
`endif
            end

            case (state_r)
                IDLE: begin
                    cnt_r     <= CNT_ZERO;
                    bit_idx_r <= 3'd0;
                    if (!rx_s) begin
                        state_r <= START;
                    end else begin
                        state_r <= IDLE;
                    end
                end

                START: begin
                    if (cnt_r == CNT_HALF) begin
                        cnt_r <= CNT_ZERO;
                        // A line that is high again at mid-bit was only a glitch.
                        if (!rx_s) begin
                            state_r <= DATA;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                DATA: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= CNT_ZERO;
                        shift_r <= {rx_s, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            bit_idx_r <= 3'd0;
`ifdef UART_RX_PARITY_EN
                            state_r   <= PARITY;
`else
                            state_r   <= STOP;
`endif
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r     <= CNT_ZERO;
                        par_mis_r <= parity_mismatch(shift_r, rx_s);
                        state_r   <= STOP;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
`endif

                STOP: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r <= CNT_ZERO;
                        if (rx_s) begin
                            // The byte is delivered at mid stop bit. The FSM
                            // returns to IDLE at once to catch the next start.
                            ParalelOut <= shift_r;
                            DataReady  <= 1'b1;
                            Overrun    <= (Overrun | DataReady) & ~Ack;
`ifdef UART_RX_PARITY_EN
                            ParErr     <= par_mis_r;
`endif
                            state_r    <= IDLE;
                        end else begin
                            FrameErr <= 1'b1;
                            state_r  <= BREAK;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                BREAK: begin
                    // Wait out a held-low line so it cannot start new frames.
                    if (rx_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= BREAK;
                    end
                end

                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_deserializer
//
// Directed bench for uart_rx_deserializer, with OVERSAMPLE=16. Frames are
// driven one clock at a time. The bench observes outputs 1 time unit after
// each rising edge.
//
// The bench drives a line change just after edge E. The synchronizer delays
// it, so the receiver's cycle 0 is edge E+3. The stop-bit sample at receiver
// cycle STOP_CYCLE is therefore observed in loop iteration STOP_CYCLE+2.
// ---------------------------------------------------------------------------
module tb_uart_rx_deserializer;

    localparam int   OS      = 16;
    localparam logic PAR_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam int   NBITS   = 11;
`else
    localparam int   NBITS   = 10;
`endif
    localparam int STOP_CYCLE = OS / 2 + (NBITS - 1) * OS;
    localparam int DELIV_C    = STOP_CYCLE + 2;
    localparam int FRAME_IT   = NBITS * OS;

    logic       clock;
    logic       reset;
    logic       SerialIn;
    logic       Ack;
    logic [7:0] ParalelOut;
    logic       DataReady;
    logic       FrameErr;
    logic       Overrun;
    logic       ParErr;
    logic       Idle;

    int n_compared;
    int n_mismatched;

    // Snapshots taken around the stop-bit sampling edge of each frame
    logic       pre_dr;
    logic       pre_idle;
    logic       post_dr;
    logic       post_ovr;
    logic       post_perr;
    logic       post_idle;
    logic [7:0] post_data;
    int         fe_cnt;
    int         fe_iter;

    uart_rx_deserializer #(
        .OVERSAMPLE (OS),
        .PARITY_ODD (int'(PAR_ODD))
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .SerialIn   (SerialIn),
        .Ack        (Ack),
        .ParalelOut (ParalelOut),
        .DataReady  (DataReady),
        .FrameErr   (FrameErr),
        .Overrun    (Overrun),
        .ParErr     (ParErr),
        .Idle       (Idle)
    );

    // 10-unit clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count one comparison and report it if it does not match
    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_compared = n_compared + 1;
        if (obs !== exp) begin
            n_mismatched = n_mismatched + 1;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Drive up to n_iter clocks of one frame.
    // par_flip inverts the correct parity bit.
    // With ack_deliv set, Ack is high on the delivery edge.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input logic par_flip, input int n_iter,
                              input logic ack_deliv);
        logic [10:0] bits;
        logic        par_bit;
        par_bit = (^data) ^ PAR_ODD ^ par_flip;
        bits    = 11'h7FF;
        bits[0] = 1'b0;
        bits[8:1] = data;
`ifdef UART_RX_PARITY_EN
        bits[9]  = par_bit;
        bits[10] = stop_bit;
`else
        bits[9]  = stop_bit;
`endif
        fe_cnt  = 0;
        fe_iter = -1;
        for (int c = 0; c < n_iter; c++) begin
            SerialIn = bits[c / OS];
            Ack      = ack_deliv && (c == DELIV_C);
            @(posedge clock);
            #1;
            if (FrameErr) begin
                fe_cnt = fe_cnt + 1;
                if (fe_iter < 0) fe_iter = c;
            end
            if (c == DELIV_C - 1) begin
                pre_dr   = DataReady;
                pre_idle = Idle;
            end
            if (c == DELIV_C) begin
                post_dr   = DataReady;
                post_ovr  = Overrun;
                post_perr = ParErr;
                post_idle = Idle;
                post_data = ParalelOut;
            end
        end
        Ack = 1'b0;
    endtask

    initial begin
        int act;
        int idle_hi;
        logic idle_c4;
        logic idle_c9;

        n_compared   = 0;
        n_mismatched = 0;
        reset    = 1'b1;
        SerialIn = 1'b1;
        Ack      = 1'b0;

        // Reset for 3 cycles with the line high
        tick(3);
        check_value("rst_data",    32'(ParalelOut), 32'h00);
        check_value("rst_ready",   32'(DataReady),  32'h0);
        check_value("rst_frerr",   32'(FrameErr),   32'h0);
        check_value("rst_overrun", 32'(Overrun),    32'h0);
        check_value("rst_parerr",  32'(ParErr),     32'h0);
        check_value("rst_idle",    32'(Idle),       32'h1);
        reset = 1'b0;

        // An idle line produces no activity
        act = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (DataReady || FrameErr || !Idle) act = act + 1;
        end
        check_value("idle_activity", 32'(act), 32'h0);

        // Byte 0xA5 is delivered on the stop-sample edge
        send_frame(8'hA5, 1'b1, 1'b0, FRAME_IT, 1'b0);
        check_value("a5_pre_ready",  32'(pre_dr),    32'h0);
        check_value("a5_pre_idle",   32'(pre_idle),  32'h0);
        check_value("a5_ready",      32'(post_dr),   32'h1);
        check_value("a5_data",       32'(post_data), 32'hA5);
        check_value("a5_idle",       32'(post_idle), 32'h1);
        check_value("a5_overrun",    32'(post_ovr),  32'h0);
        check_value("a5_parerr",     32'(post_perr), 32'h0);
        check_value("a5_frerr_cnt",  32'(fe_cnt),    32'h0);
        Ack = 1'b1;
        tick(1);
        Ack = 1'b0;
        check_value("a5_ack_ready",  32'(DataReady), 32'h0);
        check_value("a5_ack_data",   32'(ParalelOut), 32'hA5);

        // A 4-cycle low glitch is a false start
        act = 0;
        idle_c4 = 1'b1;
        idle_c9 = 1'b0;
        for (int c = 0; c < 30; c++) begin
            SerialIn = (c < 4) ? 1'b0 : 1'b1;
            tick(1);
            if (DataReady || FrameErr) act = act + 1;
            if (c == 6)  idle_c4 = Idle;
            if (c == 11) idle_c9 = Idle;
        end
        check_value("glitch_started", 32'(idle_c4), 32'h0);
        check_value("glitch_idle_c9", 32'(idle_c9), 32'h1);
        check_value("glitch_activity", 32'(act),    32'h0);

        // 0x3C with a low stop bit, then the line held low
        send_frame(8'h3C, 1'b0, 1'b0, FRAME_IT, 1'b0);
        check_value("fe_iter",   32'(fe_iter),  32'(DELIV_C));
        check_value("fe_ready",  32'(post_dr),  32'h0);
        check_value("fe_idle",   32'(post_idle), 32'h0);
        check_value("fe_data",   32'(post_data), 32'hA5);
        idle_hi = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (FrameErr) fe_cnt = fe_cnt + 1;
            if (Idle) idle_hi = idle_hi + 1;
        end
        check_value("fe_pulse_cnt", 32'(fe_cnt),  32'h1);
        check_value("break_held",   32'(idle_hi), 32'h0);
        SerialIn = 1'b1;
        tick(5);
        check_value("break_exit",   32'(Idle),      32'h1);
        check_value("break_ready",  32'(DataReady), 32'h0);

        // Back-to-back bytes without Ack cause an overrun
        send_frame(8'h11, 1'b1, 1'b0, FRAME_IT, 1'b0);
        check_value("b11_data",    32'(post_data), 32'h11);
        check_value("b11_overrun", 32'(post_ovr),  32'h0);
        send_frame(8'h22, 1'b1, 1'b0, FRAME_IT, 1'b0);
        check_value("b22_data",    32'(post_data), 32'h22);
        check_value("b22_ready",   32'(post_dr),   32'h1);
        check_value("b22_overrun", 32'(post_ovr),  32'h1);
        // Ack on the same edge that 0x33 completes: the new byte wins
        send_frame(8'h33, 1'b1, 1'b0, FRAME_IT, 1'b1);
        check_value("b33_data",    32'(post_data), 32'h33);
        check_value("b33_ready",   32'(post_dr),   32'h1);
        check_value("b33_overrun", 32'(post_ovr),  32'h0);
        Ack = 1'b1;
        tick(1);
        Ack = 1'b0;
        check_value("b33_ack_ready", 32'(DataReady), 32'h0);
        // Ack with nothing pending changes nothing
        Ack = 1'b1;
        tick(1);
        Ack = 1'b0;
        check_value("idle_ack_ready",   32'(DataReady),  32'h0);
        check_value("idle_ack_overrun", 32'(Overrun),    32'h0);
        check_value("idle_ack_data",    32'(ParalelOut), 32'h33);

        // Reset 60 cycles into a frame drops the partial byte
        send_frame(8'h5A, 1'b1, 1'b0, 60, 1'b0);
        reset    = 1'b1;
        SerialIn = 1'b1;
        tick(3);
        check_value("midrst_data",  32'(ParalelOut), 32'h00);
        check_value("midrst_ready", 32'(DataReady),  32'h0);
        check_value("midrst_idle",  32'(Idle),       32'h1);
        reset = 1'b0;
        act = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (DataReady || FrameErr) act = act + 1;
        end
        check_value("midrst_nobyte", 32'(act), 32'h0);
        send_frame(8'hC3, 1'b1, 1'b0, FRAME_IT, 1'b0);
        check_value("after_rst_data",  32'(post_data), 32'hC3);
        check_value("after_rst_ready", 32'(post_dr),   32'h1);
        Ack = 1'b1;
        tick(1);
        Ack = 1'b0;

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones, so the even parity bit should be 1.
        // Sending 0 must flag a mismatch.
        send_frame(8'h07, 1'b1, 1'b1, FRAME_IT, 1'b0);
        check_value("par_bad_ready",  32'(post_dr),   32'h1);
        check_value("par_bad_data",   32'(post_data), 32'h07);
        check_value("par_bad_parerr", 32'(post_perr), 32'h1);
        Ack = 1'b1;
        tick(1);
        Ack = 1'b0;
        check_value("par_ack_parerr", 32'(ParErr),    32'h0);
        send_frame(8'h07, 1'b1, 1'b0, FRAME_IT, 1'b0);
        check_value("par_ok_data",    32'(post_data), 32'h07);
        check_value("par_ok_parerr",  32'(post_perr), 32'h0);
        Ack = 1'b1;
        tick(1);
        Ack = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_compared, n_mismatched);
        $finish;
    end

endmodule
